// File: rtl/fp_sgnj_d_issue_if.sv
// Handshake bundle between the FP issue stage, its producer and the sign-injection unit.
// The slave modport is the issue stage's view; master is the surrounding pipeline.
interface fp_sgnj_d_issue_if #(
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [63:0]      in_rs1;
    logic [63:0]      in_rs2;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_a;
    logic [63:0]      out_b;
    logic [1:0]       out_op;
    logic [4:0]       out_rd;
    logic             illegal_valid;
    logic [31:0]      illegal_instr;
    logic [CNT_W-1:0] issue_cnt;

    modport master (
        output flush, in_valid, in_instr, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_op, out_rd,
               illegal_valid, illegal_instr, issue_cnt
    );

    modport slave (
        input  flush, in_valid, in_instr, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, out_a, out_b, out_op, out_rd,
               illegal_valid, illegal_instr, issue_cnt
    );
endinterface

// File: rtl/fp_sgnj_d_issue.sv
// Issue stage for FSGNJ/FSGNJN/FSGNJX.D: decodes OP-FP words, queues legal ones in a
// small FIFO and presents the head to the sign-injection unit; flags everything else.
module fp_sgnj_d_issue #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_sgnj_d_issue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W:0] ptr_t;

    localparam ptr_t             PTR_ONE = ptr_t'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [63:0] mem_a  [DEPTH];
    logic [63:0] mem_b  [DEPTH];
    logic [1:0]  mem_op [DEPTH];
    logic [4:0]  mem_rd [DEPTH];

    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             ill_valid;
    logic [31:0]      ill_instr;

    logic             empty;
    logic             full;
    logic             in_ready;
    logic             accept;
    logic             legal;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] head;

    // Pointers carry one extra wrap bit: equal indices with differing wrap bits means full.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign in_ready = !full && !bus.flush;
    assign accept   = bus.in_valid && in_ready;

    assign legal = (bus.in_instr[6:0]   == 7'b1010011) &&
                   (bus.in_instr[31:25] == 7'b0010001) &&
                   ((bus.in_instr[14:12] == 3'b000) ||
                    (bus.in_instr[14:12] == 3'b001) ||
                    (bus.in_instr[14:12] == 3'b010));

    assign push = accept && legal;
    assign pop  = !empty && bus.out_ready;
    assign head = rd_ptr[PTR_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ill_valid <= 1'b0;
            ill_instr <= '0;
        end else begin
            if (pop) begin
                cnt <= cnt + CNT_ONE;
            end
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
            // accept is already masked by flush, so a flush also clears the pulse.
            ill_valid <= accept && !legal;
            if (accept && !legal) begin
                ill_instr <= bus.in_instr;
            end
        end
    end

    // funct3 000/001/010 maps straight onto op 00/01/10 via its low two bits.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr[PTR_W-1:0]]  <= bus.in_rs1;
            mem_b[wr_ptr[PTR_W-1:0]]  <= bus.in_rs2;
            mem_op[wr_ptr[PTR_W-1:0]] <= bus.in_instr[13:12];
            mem_rd[wr_ptr[PTR_W-1:0]] <= bus.in_instr[11:7];
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = !empty;
    assign bus.out_a         = empty ? '0 : mem_a[head];
    assign bus.out_b         = empty ? '0 : mem_b[head];
    assign bus.out_op        = empty ? '0 : mem_op[head];
    assign bus.out_rd        = empty ? '0 : mem_rd[head];
    assign bus.illegal_valid = ill_valid;
    assign bus.illegal_instr = ill_instr;
    assign bus.issue_cnt     = cnt;
endmodule

// File: tb/tb_fp_sgnj_d_issue.sv
// Scoreboard bench for fp_sgnj_d_issue: stimulus queues expected head entries, a negedge
// monitor pops and compares them whenever the DUT hands an entry downstream.
module tb_fp_sgnj_d_issue;
    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  op;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    fp_sgnj_d_issue_if #(.CNT_W(16)) bus ();

    fp_sgnj_d_issue #(.DEPTH(2), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mkInstr(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0010001, 5'd11, 5'd10, f3, rd, 7'b1010011};
    endfunction

    // Holds the word on the input until accepted; the expectation is queued after the edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic [63:0] rs1,
                                 input logic [63:0] rs2, input bit legal,
                                 input logic [1:0] op, input logic [4:0] rd);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            done = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (done && legal) sbq.push_back('{rs1, rs2, op, rd});
        checkOutput("accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sbq.size() != 0; k++) tick();
        checkOutput("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("valid_vs_scoreboard", 64'(bus.out_valid), 64'(sbq.size() != 0));
            if (bus.out_valid && bus.out_ready && sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("head_a", bus.out_a, e.a);
                checkOutput("head_b", bus.out_b, e.b);
                checkOutput("head_op", 64'(bus.out_op), 64'(e.op));
                checkOutput("head_rd", 64'(bus.out_rd), 64'(e.rd));
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL global_timeout: actual=stuck required=finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();

        @(negedge clk);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_illegal_valid", 64'(bus.illegal_valid), 64'd0);
        checkOutput("rst_illegal_instr", 64'(bus.illegal_instr), 64'd0);
        checkOutput("rst_issue_cnt", 64'(bus.issue_cnt), 64'd0);
        checkOutput("rst_out_a", bus.out_a, 64'd0);
        checkOutput("rst_out_b", bus.out_b, 64'd0);
        checkOutput("rst_out_op", 64'(bus.out_op), 64'd0);
        checkOutput("rst_out_rd", 64'(bus.out_rd), 64'd0);
        tick();
        rst_n = 1'b1;

        $display("[TB] single fsgnj.d");
        bus.out_ready = 1'b1;
        applyStimulus(32'h22B50553, 64'h3FF0000000000000, 64'h8000000000000000, 1'b1, 2'b00, 5'd10);
        @(negedge clk);
        checkOutput("t1_out_valid", 64'(bus.out_valid), 64'd1);
        tick();
        @(negedge clk);
        checkOutput("t1_issue_cnt", 64'(bus.issue_cnt), 64'd1);
        checkOutput("t1_out_valid_after_pop", 64'(bus.out_valid), 64'd0);
        tick();

        $display("[TB] fsgnjn then fsgnjx back-to-back");
        applyStimulus(32'h22B51553, 64'h4000000000000000, 64'hC008000000000000, 1'b1, 2'b01, 5'd10);
        applyStimulus(32'h22B522D3, 64'hBFF8000000000000, 64'h0000000000000001, 1'b1, 2'b10, 5'd5);
        drain();
        @(negedge clk);
        checkOutput("t2_issue_cnt", 64'(bus.issue_cnt), 64'd3);
        tick();

        $display("[TB] fill to full and pop one");
        bus.out_ready = 1'b0;
        applyStimulus(32'h22B50553, 64'h1111111111111111, 64'h2222222222222222, 1'b1, 2'b00, 5'd10);
        applyStimulus(32'h22B51553, 64'h3333333333333333, 64'h4444444444444444, 1'b1, 2'b01, 5'd10);
        @(negedge clk);
        checkOutput("t3_full_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("t3_head_stable", bus.out_a, 64'h1111111111111111);
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("t3_in_ready_during_pop", 64'(bus.in_ready), 64'd0);
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("t3_in_ready_after_pop", 64'(bus.in_ready), 64'd1);
        checkOutput("t3_next_head", bus.out_a, 64'h3333333333333333);
        tick();
        bus.out_ready = 1'b1;
        drain();
        @(negedge clk);
        checkOutput("t3_issue_cnt", 64'(bus.issue_cnt), 64'd5);
        tick();

        $display("[TB] illegal encodings");
        applyStimulus(32'h22B53553, 64'h5, 64'h6, 1'b0, 2'b00, 5'd0);
        @(negedge clk);
        checkOutput("t4_illegal_valid", 64'(bus.illegal_valid), 64'd1);
        checkOutput("t4_illegal_instr", 64'(bus.illegal_instr), 64'h22B53553);
        checkOutput("t4_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("t4_illegal_pulse_end", 64'(bus.illegal_valid), 64'd0);
        checkOutput("t4_illegal_instr_held", 64'(bus.illegal_instr), 64'h22B53553);
        tick();
        applyStimulus(32'h20B50553, 64'h7, 64'h8, 1'b0, 2'b00, 5'd0);
        @(negedge clk);
        checkOutput("t4_funct7_illegal", 64'(bus.illegal_valid), 64'd1);
        checkOutput("t4_funct7_instr", 64'(bus.illegal_instr), 64'h20B50553);
        checkOutput("t4_issue_cnt", 64'(bus.issue_cnt), 64'd5);
        tick();

        $display("[TB] flush with two entries queued");
        bus.out_ready = 1'b0;
        applyStimulus(32'h22B52553, 64'h5555555555555555, 64'h6666666666666666, 1'b1, 2'b10, 5'd10);
        applyStimulus(32'h22B50553, 64'h7777777777777777, 64'h8888888888888888, 1'b1, 2'b00, 5'd10);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h22B51553;
        @(negedge clk);
        checkOutput("t5_in_ready_flush", 64'(bus.in_ready), 64'd0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        sbq.delete();
        @(negedge clk);
        checkOutput("t5_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t5_issue_cnt", 64'(bus.issue_cnt), 64'd5);
        tick();
        bus.out_ready = 1'b1;
        applyStimulus(32'h22B51553, 64'h9999999999999999, 64'hAAAAAAAAAAAAAAAA, 1'b1, 2'b01, 5'd10);
        drain();
        bus.out_ready = 1'b0;
        applyStimulus(32'h22B50553, 64'hBBBBBBBBBBBBBBBB, 64'hCCCCCCCCCCCCCCCC, 1'b1, 2'b00, 5'd10);
        applyStimulus(32'h22B52553, 64'hDDDDDDDDDDDDDDDD, 64'hEEEEEEEEEEEEEEEE, 1'b1, 2'b10, 5'd10);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        sbq.delete();
        @(negedge clk);
        checkOutput("t5_flush_pop_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t5_flush_pop_cnt", 64'(bus.issue_cnt), 64'd7);
        tick();

        $display("[TB] counter wrap and mid-stream reset");
        bus.out_ready = 1'b1;
        begin
            int n;
            n = 65535 - int'(exp_cnt);
            for (int i = 0; i < n; i++) begin
                logic [1:0] op;
                op = 2'(i % 3);
                applyStimulus(mkInstr({1'b0, op}, 5'(i % 32)), 64'(i), {32'(i), 32'hFFFF0000},
                              1'b1, op, 5'(i % 32));
            end
        end
        drain();
        @(negedge clk);
        checkOutput("t6_cnt_max", 64'(bus.issue_cnt), 64'hFFFF);
        tick();
        applyStimulus(32'h22B51553, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1, 2'b01, 5'd10);
        drain();
        @(negedge clk);
        checkOutput("t6_cnt_wrap", 64'(bus.issue_cnt), 64'd0);
        tick();
        bus.out_ready = 1'b0;
        applyStimulus(32'h22B50553, 64'h1, 64'h2, 1'b1, 2'b00, 5'd10);
        applyStimulus(32'h22B52553, 64'h3, 64'h4, 1'b1, 2'b10, 5'd10);
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sbq.delete();
        exp_cnt = '0;
        @(negedge clk);
        checkOutput("t6_reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t6_reset_issue_cnt", 64'(bus.issue_cnt), 64'd0);
        checkOutput("t6_reset_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
